// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-4 registered demultiplexer
package demux_pkg;
   localparam int NUM_OUT    = 4;
   localparam int SEL_W      = 2;
   localparam int LANE_DEPTH = 2;
   typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

// File: rtl/demux_lane.sv
// demux_lane: 2-entry FIFO for one output lane, count plus read pointer
module demux_lane
   import demux_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = LANE_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] rdata
);
   logic [1:0]       count_q, count_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             do_push, do_pop, wr_ptr;

   assign full  = count_q == 2'(DEPTH);
   assign valid = count_q != 2'd0;
   assign rdata = valid ? mem_q[rd_ptr_q] : '0;

   // next-state: write slot sits one past the head when one entry is held
   always_comb begin
      do_push       = push && !full;
      do_pop        = valid && ready;
      wr_ptr        = rd_ptr_q ^ count_q[0];
      mem_d         = mem_q;
      if (do_push) mem_d[wr_ptr] = wdata;
      rd_ptr_d      = rd_ptr_q ^ do_pop;
      count_d       = count_q + 2'(do_push) - 2'(do_pop);
   end

   // state registers, cleared by reset so buffered words are discarded
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         rd_ptr_q <= 1'b0;
         mem_q    <= '{default: '0};
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/demux.sv
// demux: steers one input stream into four independently back-pressured lane FIFOs
module demux
   import demux_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = LANE_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  lane_sel_t                sel,
   output logic [NUM_OUT-1:0]       out_valid,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [NUM_OUT*WIDTH-1:0] out_data
);
   logic [NUM_OUT-1:0] full, push;

   // ready depends only on registered occupancy of the addressed lane
   assign in_ready = !reset && !full[sel];

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
      assign push[i] = in_valid && in_ready && (sel == lane_sel_t'(i));
      demux_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
         .clk   (clk),
         .reset (reset),
         .push  (push[i]),
         .wdata (in_data),
         .full  (full[i]),
         .valid (out_valid[i]),
         .ready (out_ready[i]),
         .rdata (out_data[i*WIDTH +: WIDTH])
      );
   end
endmodule

// File: tb/tb_demux.sv
// tb_demux: vector table plus directed sequences and a scoreboard soak for demux
module tb_demux;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;

   int n_chk = 0;
   int n_fail = 0;

   demux #(.WIDTH(8), .DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        v;
      logic [1:0]  sel;
      logic [7:0]  d;
      logic [3:0]  ordy;
      logic        e_ir;
      logic [3:0]  e_ov;
      logic [31:0] e_od;
   } vec_t;

   vec_t tbl [15];
   logic [7:0] q [4][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] o);
      reset = r; in_valid = v; sel = s; in_data = d; out_ready = o;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'hF, 1'b0, 4'h0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 4'hF, 1'b0, 4'h0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 4'h0, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'h0, 1'b1, 4'h0, 32'h0};
      tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h4, 1'b1, 4'h4, 32'h00A5_0000};
      tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 4'h0, 32'h0};
      tbl[6]  = '{1'b0, 1'b1, 2'd1, 8'h11, 4'h0, 1'b1, 4'h0, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, 2'd1, 8'h22, 4'h0, 1'b1, 4'h2, 32'h0000_1100};
      tbl[8]  = '{1'b0, 1'b1, 2'd1, 8'h33, 4'h0, 1'b0, 4'h2, 32'h0000_1100};
      tbl[9]  = '{1'b0, 1'b1, 2'd1, 8'h33, 4'h2, 1'b0, 4'h2, 32'h0000_1100};
      tbl[10] = '{1'b0, 1'b1, 2'd1, 8'h33, 4'h0, 1'b1, 4'h2, 32'h0000_2200};
      tbl[11] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h2, 1'b1, 4'h2, 32'h0000_2200};
      tbl[12] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h2, 1'b1, 4'h2, 32'h0000_3300};
      tbl[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 4'h0, 32'h0};
      tbl[14] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 32'h0};

      drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
      step();

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_od);
         step();
      end

      // push and pop together on lane 0 holding one word
      drive(1'b0, 1'b1, 2'd0, 8'h01, 4'h0);
      step();
      drive(1'b0, 1'b1, 2'd0, 8'h02, 4'h1);
      chk("pp in_ready", 32'(in_ready), 32'h1);
      chk("pp head_old", 32'(out_data[7:0]), 32'h01);
      step();
      drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
      chk("pp valid", 32'(out_valid), 32'h1);
      chk("pp head_new", 32'(out_data[7:0]), 32'h02);
      drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h1);
      step();
      drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
      chk("pp drained", 32'(out_valid), 32'h0);

      // lane 0 full and stalled while lane 3 streams
      drive(1'b0, 1'b1, 2'd0, 8'hAA, 4'h0); step();
      drive(1'b0, 1'b1, 2'd0, 8'hBB, 4'h0); step();
      drive(1'b0, 1'b1, 2'd0, 8'hCC, 4'h0);
      chk("ind lane0 full ready", 32'(in_ready), 32'h0);
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b1, 2'd3, 8'(8'h30 + k), 4'h8);
         chk($sformatf("ind%0d in_ready", k), 32'(in_ready), 32'h1);
         chk($sformatf("ind%0d valid", k), 32'(out_valid), k == 0 ? 32'h1 : 32'h9);
         chk($sformatf("ind%0d lane3", k), 32'(out_data[31:24]), k == 0 ? 32'h0 : 32'(8'h30 + k - 1));
         chk($sformatf("ind%0d lane0", k), 32'(out_data[7:0]), 32'hAA);
         step();
      end
      drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h8);
      chk("ind lane3 last", 32'(out_data[31:24]), 32'h35);
      step();
      drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h1);
      chk("ind lane0 first", 32'(out_data), 32'h0000_00AA);
      step();
      drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h1);
      chk("ind lane0 second", 32'(out_data), 32'h0000_00BB);
      step();

      // random soak against per-lane queue model
      for (int c = 0; c < 10000; c++) begin
         logic        v, exp_ir;
         logic [1:0]  s;
         logic [7:0]  d;
         logic [3:0]  o;
         v = ($urandom_range(0, 9) < 7);
         s = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         o = 4'($urandom);
         drive(1'b0, v, s, d, o);
         exp_ir = q[s].size() < 2;
         chk("soak in_ready", 32'(in_ready), 32'(exp_ir));
         for (int l = 0; l < 4; l++) begin
            chk($sformatf("soak valid%0d", l), 32'(out_valid[l]), 32'(q[l].size() != 0));
            chk($sformatf("soak data%0d", l), 32'(out_data[l*8 +: 8]), q[l].size() != 0 ? 32'(q[l][0]) : 32'h0);
         end
         for (int l = 0; l < 4; l++)
            if (o[l] && q[l].size() != 0) void'(q[l].pop_front());
         if (v && exp_ir) q[s].push_back(d);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
